// File: rtl/fifo_rd_stream_adapter_pkg.sv
// fifo_rd_stream_adapter_pkg: adapter state encoding and data width shared with Async_FIFO
package fifo_rd_stream_adapter_pkg;
  localparam int FIFO_DATA_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, CONT} state_t;
endpackage

// File: rtl/stream_skid_buf.sv
// stream_skid_buf: 2-entry in-order buffer, head drives data/valid, concurrent push+pop allowed
module stream_skid_buf
  import fifo_rd_stream_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  r_clk,
  input  logic                  rrst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [1:0]            occ
);
  logic [DATA_WIDTH-1:0] head, tail;
  logic head_we, tail_we;
  assign valid = occ != 2'd0;
  assign data = head;
  assign head_we = pop ? (occ == 2'd2 || push) : (push && occ == 2'd0);
  assign tail_we = push && (pop ? occ == 2'd2 : occ == 2'd1);
  always_ff @(posedge r_clk or negedge rrst) begin
    if (!rrst) begin
      occ <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      occ <= occ + {1'b0, push} - {1'b0, pop};
      if (head_we) head <= (pop && occ == 2'd2) ? tail : push_data;
      if (tail_we) tail <= push_data;
    end
  end
endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: FIFO pop interface (1-cycle read latency) to valid/ready stream, burst or continuous
module fifo_rd_stream_adapter
  import fifo_rd_stream_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  r_clk,
  input  logic                  rrst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_req,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  input  logic                  enable,
  input  logic                  burst_start,
  input  logic [CNT_WIDTH-1:0]  burst_len,
  output logic                  burst_done,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  words_out
);
  state_t state;
  logic inflight, pop, drained;
  logic [1:0] occ;
  logic [2:0] pend;
  logic [CNT_WIDTH-1:0] len, issued;
  assign pop = m_valid && m_ready;
  assign pend = {1'b0, occ} + {2'b0, inflight};
  assign drained = pend == {2'b0, pop};
  assign busy = state != IDLE;
  assign fifo_rd_req = ((state == RUN && issued != len) || (state == CONT && enable))
                       && !fifo_empty && pend < 3'd2 + {2'b0, pop};
  stream_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .r_clk     (r_clk),
    .rrst      (rrst),
    .push      (inflight),
    .push_data (fifo_data_out),
    .pop       (pop),
    .valid     (m_valid),
    .data      (m_data),
    .occ       (occ)
  );
  always_ff @(posedge r_clk or negedge rrst) begin
    if (!rrst) begin
      state <= IDLE;
      inflight <= 1'b0;
      len <= '0;
      issued <= '0;
      words_out <= '0;
      burst_done <= 1'b0;
    end else begin
      inflight <= fifo_rd_req;
      burst_done <= 1'b0;
      if (pop) words_out <= words_out + CNT_WIDTH'(1);
      case (state)
        IDLE: if (burst_start) begin
          words_out <= '0;
          issued <= '0;
          len <= burst_len;
          state <= burst_len != '0 ? RUN : CONT;
        end
        RUN: if (fifo_rd_req) begin
          issued <= issued + CNT_WIDTH'(1);
          if (issued + CNT_WIDTH'(1) == len) state <= FLUSH;
        end
        FLUSH: if (drained) begin
          burst_done <= 1'b1;
          state <= IDLE;
        end
        CONT: if (!enable && drained) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb_fifo_rd_stream_adapter: directed checks of the read-side adapter against a behavioural FIFO
module tb_fifo_rd_stream_adapter;
  logic r_clk = 1'b0, rrst = 1'b0;
  logic fifo_empty, fifo_rd_req, m_valid, burst_done, busy;
  logic m_ready = 1'b0, enable = 1'b0, burst_start = 1'b0, wr_en = 1'b0;
  logic [7:0] fifo_data_out, m_data, wr_d = 8'h0;
  logic [15:0] burst_len = 16'h0, words_out;
  logic [7:0] fm [0:255];
  logic [7:0] wp, rp;
  logic [7:0] pd [0:63];
  int pc [0:63];
  int n_chk = 0, n_fail = 0, cyc = 0;
  int nrd, nviol, nd, np, first_rd, first_v, dc, bad;
  always #5 r_clk = ~r_clk;
  fifo_rd_stream_adapter dut (
    .r_clk         (r_clk),
    .rrst          (rrst),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_rd_req   (fifo_rd_req),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_ready       (m_ready),
    .enable        (enable),
    .burst_start   (burst_start),
    .burst_len     (burst_len),
    .burst_done    (burst_done),
    .busy          (busy),
    .words_out     (words_out)
  );
  assign fifo_empty = wp == rp;
  always_ff @(posedge r_clk or negedge rrst) begin
    if (!rrst) begin
      wp <= 8'h0;
      rp <= 8'h0;
      fifo_data_out <= 8'h0;
    end else begin
      if (wr_en) begin
        fm[wp] <= wr_d;
        wp <= wp + 8'h1;
      end
      if (fifo_rd_req && !fifo_empty) begin
        fifo_data_out <= fm[rp];
        rp <= rp + 8'h1;
      end
    end
  end
  always @(negedge r_clk) begin
    cyc++;
    if (fifo_rd_req) begin
      nrd++;
      if (first_rd < 0) first_rd = cyc;
      if (fifo_empty) nviol++;
    end
    if (m_valid && first_v < 0) first_v = cyc;
    if (m_valid && m_ready && np < 64) begin
      pd[np] = m_data;
      pc[np] = cyc;
      np++;
    end
    if (burst_done) begin
      nd++;
      dc = cyc;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge r_clk);
      #1;
    end
  endtask
  task automatic clr();
    nrd = 0; nviol = 0; nd = 0; np = 0; first_rd = -1; first_v = -1; dc = -1;
  endtask
  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1;
    wr_d = d;
    step(1);
    wr_en = 1'b0;
  endtask
  task automatic start(input logic [15:0] len);
    burst_len = len;
    burst_start = 1'b1;
    step(1);
    burst_start = 1'b0;
  endtask
  task automatic wait_idle(input string tag, input int max);
    int k = 0;
    while (busy && k < max) begin
      step(1);
      k++;
    end
    chk(tag, {31'b0, busy}, 32'd0);
    step(1);
  endtask
  initial begin
    clr();
    step(2);
    chk("rst_valid", {31'b0, m_valid}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_words", {16'b0, words_out}, 0);
    chk("rst_done", {31'b0, burst_done}, 0);
    chk("rst_rdreq", {31'b0, fifo_rd_req}, 0);
    rrst = 1'b1;
    step(1);
    for (int i = 0; i < 4; i++) wr(8'h11 + 8'(i));
    clr();
    m_ready = 1'b1;
    start(16'd4);
    wait_idle("b4_timeout", 30);
    chk("b4_pops", np, 4);
    bad = 0;
    for (int i = 0; i < 4; i++) if (pd[i] !== 8'h11 + 8'(i)) bad++;
    chk("b4_order", bad, 0);
    chk("b4_back2back", pc[3] - pc[0], 3);
    chk("b4_latency", first_v - first_rd, 2);
    chk("b4_done_cnt", nd, 1);
    chk("b4_done_time", dc - pc[3], 1);
    chk("b4_words", {16'b0, words_out}, 4);
    for (int i = 0; i < 3; i++) wr(8'h21 + 8'(i));
    clr();
    m_ready = 1'b0;
    start(16'd3);
    step(6);
    chk("stall_rdreq", nrd, 2);
    chk("stall_valid", {31'b0, m_valid}, 1);
    chk("stall_data", {24'b0, m_data}, 32'h21);
    step(3);
    chk("stall_hold", {24'b0, m_data}, 32'h21);
    chk("stall_rdreq2", nrd, 2);
    m_ready = 1'b1;
    wait_idle("stall_timeout", 30);
    chk("stall_pops", np, 3);
    bad = 0;
    for (int i = 0; i < 3; i++) if (pd[i] !== 8'h21 + 8'(i)) bad++;
    chk("stall_order", bad, 0);
    chk("stall_done_cnt", nd, 1);
    chk("stall_words", {16'b0, words_out}, 3);
    wr(8'h31);
    wr(8'h32);
    clr();
    start(16'd5);
    step(8);
    chk("empty_busy", {31'b0, busy}, 1);
    chk("empty_nodone", nd, 0);
    chk("empty_pops", np, 2);
    for (int i = 0; i < 3; i++) wr(8'h33 + 8'(i));
    wait_idle("empty_timeout", 30);
    chk("empty_words", {16'b0, words_out}, 5);
    chk("empty_last", {24'b0, pd[4]}, 32'h35);
    chk("empty_done_cnt", nd, 1);
    chk("empty_viol", nviol, 0);
    clr();
    start(16'd2);
    step(2);
    start(16'd7);
    for (int i = 0; i < 3; i++) wr(8'h41 + 8'(i));
    wait_idle("ign_timeout", 30);
    chk("ign_pops", np, 2);
    chk("ign_d1", {24'b0, pd[1]}, 32'h42);
    chk("ign_words", {16'b0, words_out}, 2);
    chk("ign_done_cnt", nd, 1);
    chk("ign_leftover", {31'b0, fifo_empty}, 0);
    clr();
    enable = 1'b1;
    start(16'd0);
    chk("cont_busy", {31'b0, busy}, 1);
    fork
      for (int i = 0; i < 20; i++) wr(8'(i));
      repeat (80) begin
        m_ready = ~m_ready;
        step(1);
      end
    join
    m_ready = 1'b1;
    enable = 1'b0;
    wait_idle("cont_timeout", 20);
    chk("cont_pops", np, 21);
    bad = 0;
    for (int i = 0; i < 21; i++) if (pd[i] !== ((i == 0) ? 8'h43 : 8'(i - 1))) bad++;
    chk("cont_order", bad, 0);
    chk("cont_viol", nviol, 0);
    chk("cont_nodone", nd, 0);
    chk("cont_words", {16'b0, words_out}, 21);
    for (int i = 0; i < 5; i++) wr(8'h51 + 8'(i));
    clr();
    start(16'd5);
    step(3);
    m_ready = 1'b0;
    step(5);
    chk("pre_rst_valid", {31'b0, m_valid}, 1);
    chk("pre_rst_words", {31'b0, words_out != 16'd0}, 1);
    #2 rrst = 1'b0;
    #1;
    chk("arst_valid", {31'b0, m_valid}, 0);
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_words", {16'b0, words_out}, 0);
    step(2);
    rrst = 1'b1;
    m_ready = 1'b1;
    step(1);
    wr(8'h61);
    clr();
    start(16'd1);
    wait_idle("post_rst_timeout", 20);
    chk("post_rst_pops", np, 1);
    chk("post_rst_data", {24'b0, pd[0]}, 32'h61);
    chk("post_rst_words", {16'b0, words_out}, 1);
    chk("post_rst_done", nd, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_rd_stream_adapter.md
Name: fifo_rd_stream_adapter

Overview:
Read-side consumer for the team's Async_FIFO. It lives entirely in the read-clock domain. It turns the FIFO pop interface (rd_req, empty, and data_out with 1-cycle read latency) into a valid/ready stream, using a 2-entry output buffer and either burst-limited or continuous draining. It feeds downstream logic and lets the bench check FIFO order and throughput from the read side.

Parameters:
- DATA_WIDTH, 8: width of FIFO data and of m_data.
- CNT_WIDTH, 16: width of burst_len and words_out.

Ports:
- r_clk  in  1  read-domain clock; all logic on posedge.
- rrst  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  FIFO empty flag, r_clk domain.
- fifo_data_out  in  DATA_WIDTH  FIFO read data; valid the cycle after an accepted rd_req.
- fifo_rd_req  out  1  pop request to the FIFO.
- m_valid  out  1  stream data valid.
- m_data  out  DATA_WIDTH  stream data.
- m_ready  in  1  downstream accept.
- enable  in  1  continuous-mode run enable.
- burst_start  in  1  single-cycle pulse; starts a burst.
- burst_len  in  CNT_WIDTH  words per burst, sampled on burst_start; 0 selects continuous mode.
- burst_done  out  1  single-cycle pulse when a burst has fully drained.
- busy  out  1  high whenever state != IDLE.
- words_out  out  CNT_WIDTH  count of accepted stream handshakes.

Behaviour:
- Reset (rrst low, asynchronous): state=IDLE, buffer empty, inflight=0, all outputs 0. A word in flight at reset is lost; this is documented, not an error.
- Definitions: pop = m_valid && m_ready; occ = buffer occupancy (0..2); inflight = 1 if fifo_rd_req was asserted last cycle, else 0.
- fifo_rd_req is combinational and asserted iff all of these hold:
  - state is RUN, or CONT with enable=1;
  - !fifo_empty;
  - (occ + inflight - pop) < 2;
  - in RUN, issued < len.
- Read latency: fifo_rd_req high in cycle 0 -> fifo_data_out captured at the end of cycle 1 -> m_valid high from cycle 2.
- Buffer: 2-entry FIFO with head at m_data. Push and pop in the same cycle are legal. Order is preserved. m_data holds stable while m_valid && !m_ready.
- Throughput: sustains 1 word per cycle with m_ready=1 and the FIFO non-empty.
- FSM:
  - IDLE: burst_start with burst_len>0 -> RUN (loads len, clears issued and words_out). burst_start with burst_len=0 -> CONT (clears words_out).
  - RUN: issued increments on each fifo_rd_req. When issued==len -> FLUSH.
  - FLUSH: no new reads. When inflight==0 && occ==0 -> assert burst_done for 1 cycle -> IDLE.
  - CONT: reads while enable=1. When enable=0, reads stop and the buffer drains. Once drained with enable still 0 -> IDLE. No burst_done pulse in CONT.
- burst_start outside IDLE is ignored.
- fifo_empty during a burst stalls the burst; it does not abort it.
- words_out increments on each pop and wraps modulo 2^CNT_WIDTH.
- m_ready low with the buffer full forces fifo_rd_req low; the buffer never overflows.

Decomposition:
- pkg gets a state enum typedef {IDLE, RUN, FLUSH, CONT} and a DATA_WIDTH default constant shared with Async_FIFO.
- One sub-module: stream_skid_buf (2-entry buffer with push/pop/occ).

Test Plan:
- FIFO preloaded with 0x11..0x14, burst_len=4, m_ready=1 -> m_data 0x11,0x12,0x13,0x14 on 4 consecutive cycles; first m_valid 2 cycles after the first rd_req; burst_done 1 cycle after the last pop; words_out=4.
- burst_len=3, m_ready held low -> exactly 2 rd_req issued, m_valid high, m_data stable at word 0. Release m_ready -> 3 words delivered in order, burst_done pulses once.
- Continuous mode, writer stream 0..19 at w_clk=2x r_clk, m_ready toggling every cycle -> all 20 words delivered in order, no loss or duplication, fifo_rd_req never asserted while fifo_empty.
- FIFO empty mid-burst (len=5, only 2 words available) -> busy stays 1, burst_done stays 0. Write 3 more words -> burst completes, words_out=5.
- rrst asserted in RUN with occ=2 -> m_valid=0, busy=0, words_out=0 immediately. New burst_start after reset release is accepted.
- burst_start pulsed while in RUN with a different burst_len -> ignored; the original length completes.
